// File: rtl/instr_fetch_if.sv
// Fetch-unit bus: program-memory read port, counter advance/load and the
// instruction handshake toward the controller.
interface instr_fetch_if #(
    parameter int ADDR_W = 13,
    parameter int OPC_W  = 3,
    parameter int DATA_W = 8
);
    logic              fetch_en;
    logic              flush;
    logic              mem_rd;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ready;
    logic              pc_inc;
    logic              ir_valid;
    logic              ir_ready;
    logic [OPC_W-1:0]  opcode;
    logic [ADDR_W-1:0] ir_addr;
    logic              fetch_err;

    // Fetch unit side
    modport master (
        input  fetch_en, flush, mem_data, mem_ready, ir_ready,
        output mem_rd, pc_inc, ir_valid, opcode, ir_addr, fetch_err
    );

    // Memory / counter / controller side
    modport slave (
        output fetch_en, flush, mem_data, mem_ready, ir_ready,
        input  mem_rd, pc_inc, ir_valid, opcode, ir_addr, fetch_err
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: reads a 16-bit instruction as two bytes (high first) and
// pulses pc_inc per byte. Optional wait timeout enabled by FETCH_TIMEOUT_EN.
module instr_fetch #(
    parameter int ADDR_W      = 13,
    parameter int OPC_W       = 3,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic           clock,
    input  logic           rst,
    instr_fetch_if.master  bus
);
    localparam int IR_W = OPC_W + ADDR_W;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH_HI = 2'd1,
        FETCH_LO = 2'd2,
        VALID    = 2'd3
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [IR_W-1:0] ir_r;
    logic            mem_rd_r;
    logic            pc_inc_r;
    logic            ir_valid_r;
    logic            cap_hi_s;
    logic            cap_lo_s;
    logic            timeout_s;
    logic            fetch_err_s;

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] wait_cnt_r;
    logic             waiting_s;
    logic             fetch_err_r;

    assign waiting_s   = ((state_r == FETCH_HI) || (state_r == FETCH_LO)) && !bus.mem_ready;
    // The last wait cycle is the one where the counter sits one below the limit
    assign timeout_s   = waiting_s && (wait_cnt_r == CNT_W'(TIMEOUT_CYC - 1));
    assign fetch_err_s = fetch_err_r;

    // Wait counter: cleared on every state change and on each completed read
    always_ff @(posedge clock) begin
        if (rst) begin
            wait_cnt_r <= {CNT_W{1'b0}};
        end else if ((state_nxt_s != state_r) || !waiting_s) begin
            wait_cnt_r <= {CNT_W{1'b0}};
        end else begin
            wait_cnt_r <= wait_cnt_r + CNT_W'(1);
        end
    end

    // Sticky timeout flag
    always_ff @(posedge clock) begin
        if (rst) begin
            fetch_err_r <= 1'b0;
        end else if (timeout_s && !bus.flush) begin
            fetch_err_r <= 1'b1;
        end else begin
            fetch_err_r <= fetch_err_r;
        end
    end
`else
    assign timeout_s   = 1'b0;
    assign fetch_err_s = 1'b0;
`endif

    // State register and registered outputs, decoded from the next state
    always_ff @(posedge clock) begin
        if (rst) begin
            state_r    <= IDLE;
            ir_r       <= {IR_W{1'b0}};
            mem_rd_r   <= 1'b0;
            pc_inc_r   <= 1'b0;
            ir_valid_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            mem_rd_r   <= (state_nxt_s == FETCH_HI) || (state_nxt_s == FETCH_LO);
            ir_valid_r <= (state_nxt_s == VALID);
            pc_inc_r   <= cap_hi_s || cap_lo_s;
            if (cap_hi_s) begin
                ir_r[IR_W-1 -: DATA_W] <= bus.mem_data;
            end
            if (cap_lo_s) begin
                ir_r[DATA_W-1:0] <= bus.mem_data;
            end
        end
    end

    // Next-state logic; flush overrides every capture and handshake
    always_comb begin
        state_nxt_s = state_r;
        cap_hi_s    = 1'b0;
        cap_lo_s    = 1'b0;
        if (bus.flush) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.fetch_en && !fetch_err_s) begin
                        state_nxt_s = FETCH_HI;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                FETCH_HI: begin
                    if (timeout_s) begin
                        state_nxt_s = IDLE;
                    end else if (bus.mem_ready) begin
                        cap_hi_s    = 1'b1;
                        state_nxt_s = FETCH_LO;
                    end else begin
                        state_nxt_s = FETCH_HI;
                    end
                end
                FETCH_LO: begin
                    if (timeout_s) begin
                        state_nxt_s = IDLE;
                    end else if (bus.mem_ready) begin
                        cap_lo_s    = 1'b1;
                        state_nxt_s = VALID;
                    end else begin
                        state_nxt_s = FETCH_LO;
                    end
                end
                VALID: begin
                    if (bus.ir_ready) begin
                        state_nxt_s = bus.fetch_en ? FETCH_HI : IDLE;
                    end else begin
                        state_nxt_s = VALID;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end
    end

    assign bus.mem_rd    = mem_rd_r;
    assign bus.pc_inc    = pc_inc_r;
    assign bus.ir_valid  = ir_valid_r;
    assign bus.opcode    = ir_r[IR_W-1 -: OPC_W];
    assign bus.ir_addr   = ir_r[ADDR_W-1:0];
    assign bus.fetch_err = fetch_err_s;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: latency, pc_inc pulse counts, stalls, flush,
// reset mid-fetch and (with FETCH_TIMEOUT_EN) the sticky timeout.
module tb_instr_fetch;
    logic clock = 1'b0;
    logic rst   = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   pc_cnt = 0;
    int   base;
    int   lat;

    instr_fetch_if #(.ADDR_W(13), .OPC_W(3), .DATA_W(8)) bus ();

    instr_fetch #(.ADDR_W(13), .OPC_W(3), .DATA_W(8), .TIMEOUT_CYC(15)) dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus.master)
    );

    always #5 clock = ~clock;

    // Count pc_inc pulses, sampled mid-cycle
    always @(negedge clock) begin
        if (bus.pc_inc) pc_cnt = pc_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    // Serve one instruction on the memory port until ir_valid; stall_hi wait
    // cycles are inserted before the high byte.
    task automatic run_instr(input logic [7:0] hi, input logic [7:0] lo,
                             input int stall_hi, output int n);
        int idx = 0;
        int st  = stall_hi;
        logic [15:0] prev = {bus.opcode, bus.ir_addr};
        n = 0;
        while (!bus.ir_valid && n < 40) begin
            if (bus.mem_rd && idx < 2) begin
                if (idx == 0 && st > 0) begin
                    check_eq("stall_pc_inc", 32'(bus.pc_inc), 32'd0);
                    check_eq("stall_ir", 32'({bus.opcode, bus.ir_addr}), 32'(prev));
                    bus.mem_ready = 1'b0;
                    st--;
                end else begin
                    bus.mem_ready = 1'b1;
                    bus.mem_data  = (idx == 0) ? hi : lo;
                    idx++;
                end
            end else begin
                bus.mem_ready = 1'b0;
            end
            step();
            n++;
        end
        bus.mem_ready = 1'b0;
    endtask

    logic [7:0] hi_v [3] = '{8'h1F, 8'hE0, 8'h40};
    logic [7:0] lo_v [3] = '{8'hFF, 8'h01, 8'h80};
    logic [2:0] op_v [3] = '{3'd0, 3'd7, 3'd2};
    logic [12:0] ad_v [3] = '{13'h1FFF, 13'h0001, 13'h0080};

    initial begin
        bus.fetch_en  = 1'b0;
        bus.flush     = 1'b0;
        bus.mem_data  = 8'h00;
        bus.mem_ready = 1'b0;
        bus.ir_ready  = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        check_eq("rst_mem_rd",   32'(bus.mem_rd),    32'd0);
        check_eq("rst_ir_valid", 32'(bus.ir_valid),  32'd0);
        check_eq("rst_pc_inc",   32'(bus.pc_inc),    32'd0);
        check_eq("rst_opcode",   32'(bus.opcode),    32'd0);
        check_eq("rst_ir_addr",  32'(bus.ir_addr),   32'd0);
        check_eq("rst_err",      32'(bus.fetch_err), 32'd0);

        // Single fetch 0xA123
        base = pc_cnt;
        bus.fetch_en = 1'b1;
        run_instr(8'hA1, 8'h23, 0, lat);
        bus.fetch_en = 1'b0;
        check_eq("t2_latency", 32'(lat), 32'd3);
        check_eq("t2_opcode",  32'(bus.opcode),  32'd5);
        check_eq("t2_ir_addr", 32'(bus.ir_addr), 32'h0123);
        check_eq("t2_mem_rd",  32'(bus.mem_rd),  32'd0);
        step();
        step();
        check_eq("t2_hold_valid", 32'(bus.ir_valid), 32'd1);
        check_eq("t2_hold_addr",  32'(bus.ir_addr),  32'h0123);
        check_eq("t2_pc_pulses",  32'(pc_cnt - base), 32'd2);
        bus.ir_ready = 1'b1;
        step();
        bus.ir_ready = 1'b0;
        check_eq("t2_post_valid", 32'(bus.ir_valid), 32'd0);
        check_eq("t2_post_rd",    32'(bus.mem_rd),   32'd0);

        // Back-to-back, three instructions with ir_ready held
        base = pc_cnt;
        bus.fetch_en = 1'b1;
        bus.ir_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            run_instr(hi_v[k], lo_v[k], 0, lat);
            check_eq("t3_latency", 32'(lat), (k == 0) ? 32'd3 : 32'd2);
            check_eq("t3_opcode",  32'(bus.opcode),  32'(op_v[k]));
            check_eq("t3_ir_addr", 32'(bus.ir_addr), 32'(ad_v[k]));
            if (k == 2) bus.fetch_en = 1'b0;
            step();
            check_eq("t3_next_rd", 32'(bus.mem_rd), (k < 2) ? 32'd1 : 32'd0);
        end
        bus.ir_ready = 1'b0;
        step();
        check_eq("t3_pc_pulses", 32'(pc_cnt - base), 32'd6);

        // Five stall cycles before the high byte, instruction 0x7C0D
        base = pc_cnt;
        bus.fetch_en = 1'b1;
        run_instr(8'h7C, 8'h0D, 5, lat);
        bus.fetch_en = 1'b0;
        check_eq("t4_latency", 32'(lat), 32'd8);
        check_eq("t4_opcode",  32'(bus.opcode),  32'd3);
        check_eq("t4_ir_addr", 32'(bus.ir_addr), 32'h1C0D);
        bus.ir_ready = 1'b1;
        step();
        bus.ir_ready = 1'b0;
        check_eq("t4_pc_pulses", 32'(pc_cnt - base), 32'd2);

        // Flush together with mem_ready in FETCH_LO
        base = pc_cnt;
        bus.fetch_en = 1'b1;
        step();
        bus.fetch_en  = 1'b0;
        bus.mem_ready = 1'b1;
        bus.mem_data  = 8'h55;
        step();
        bus.mem_data = 8'h66;
        bus.flush    = 1'b1;
        step();
        bus.flush     = 1'b0;
        bus.mem_ready = 1'b0;
        check_eq("t5_ir_valid", 32'(bus.ir_valid), 32'd0);
        check_eq("t5_mem_rd",   32'(bus.mem_rd),   32'd0);
        check_eq("t5_pc_inc",   32'(bus.pc_inc),   32'd0);
        check_eq("t5_ir_addr",  32'(bus.ir_addr),  32'h150D);
        step();
        check_eq("t5_pc_pulses", 32'(pc_cnt - base), 32'd1);

        // Flush in IDLE blocks a fetch start
        bus.fetch_en = 1'b1;
        bus.flush    = 1'b1;
        step();
        check_eq("idle_flush_rd", 32'(bus.mem_rd), 32'd0);
        bus.fetch_en = 1'b0;
        bus.flush    = 1'b0;
        step();

        // Reset held two cycles while in FETCH_LO
        bus.fetch_en = 1'b1;
        step();
        bus.mem_ready = 1'b1;
        bus.mem_data  = 8'h99;
        step();
        bus.mem_ready = 1'b0;
        bus.fetch_en  = 1'b0;
        check_eq("t1_in_lo_rd", 32'(bus.mem_rd), 32'd1);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check_eq("t1_mem_rd",   32'(bus.mem_rd),   32'd0);
        check_eq("t1_pc_inc",   32'(bus.pc_inc),   32'd0);
        check_eq("t1_ir_valid", 32'(bus.ir_valid), 32'd0);
        check_eq("t1_ir",       32'({bus.opcode, bus.ir_addr}), 32'd0);
        step();
        check_eq("t1_idle_rd",  32'(bus.mem_rd),   32'd0);

`ifdef FETCH_TIMEOUT_EN
        // mem_ready stuck low: timeout after 15 wait cycles, then locked out
        bus.fetch_en = 1'b1;
        step();
        for (int i = 0; i < 14; i++) step();
        check_eq("t6_pre_err", 32'(bus.fetch_err), 32'd0);
        check_eq("t6_pre_rd",  32'(bus.mem_rd),    32'd1);
        step();
        check_eq("t6_err",     32'(bus.fetch_err), 32'd1);
        check_eq("t6_rd",      32'(bus.mem_rd),    32'd0);
        for (int i = 0; i < 4; i++) step();
        check_eq("t6_locked_rd",  32'(bus.mem_rd),    32'd0);
        check_eq("t6_sticky_err", 32'(bus.fetch_err), 32'd1);
        bus.fetch_en = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("t6_rst_err", 32'(bus.fetch_err), 32'd0);
`else
        check_eq("no_timeout_err", 32'(bus.fetch_err), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
